// File: rtl/lmsm_sequencer_if.sv
// Decode-side and execute-side handshake signals of the LM/SM sequencer.
interface lmsm_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8
);
  localparam int unsigned REG_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_base;
  logic [NREG-1:0]   in_mask;
  logic              uop_valid;
  logic              uop_ready;
  logic              uop_load;
  logic [REG_W-1:0]  uop_reg;
  logic [ADDR_W-1:0] uop_addr;

  modport slave (
    input  in_valid, in_op, in_base, in_mask, uop_ready,
    output in_ready, uop_valid, uop_load, uop_reg, uop_addr
  );

  modport master (
    output in_valid, in_op, in_base, in_mask, uop_ready,
    input  in_ready, uop_valid, uop_load, uop_reg, uop_addr
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Walks an LM/SM register list, issuing one single-register load/store
// micro-op per handshake in ascending register order at base+k.
module lmsm_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8,
  parameter logic [3:0]  OP_LM  = 4'b0110,
  parameter logic [3:0]  OP_SM  = 4'b0111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  lmsm_sequencer_if.slave     bus,
  output logic                busy,
  output logic                done
);
  localparam int unsigned REG_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic              load_q, load_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [NREG-1:0]   rem;
  logic              accept;

  function automatic logic [REG_W-1:0] lowest(input logic [NREG-1:0] m);
    logic [REG_W-1:0] r;
    r = '0;
    for (int unsigned i = NREG; i > 0; i--) begin
      if (m[i-1]) r = REG_W'(i - 1);
    end
    return r;
  endfunction

  assign bus.in_ready  = (state_q == IDLE) && !flush;
  assign accept        = bus.in_valid && bus.in_ready &&
                         (bus.in_op == OP_LM || bus.in_op == OP_SM);
  assign bus.uop_valid = valid_q;
  assign bus.uop_load  = load_q;
  assign bus.uop_reg   = reg_q;
  assign bus.uop_addr  = addr_q;
  assign busy          = (state_q == RUN);
  assign done          = done_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    load_d  = load_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    rem     = mask_q;
    rem[reg_q] = 1'b0;

    if (flush) begin
      // A micro-op consumed in this cycle is owned downstream; only the walk is aborted.
      state_d = IDLE;
      valid_d = 1'b0;
      mask_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            load_d = (bus.in_op == OP_LM);
            addr_d = bus.in_base;
            if (bus.in_mask != '0) begin
              mask_d  = bus.in_mask;
              reg_d   = lowest(bus.in_mask);
              valid_d = 1'b1;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (valid_q && bus.uop_ready) begin
            addr_d = addr_q + 1'b1;
            mask_d = rem;
            if (rem != '0) begin
              reg_d = lowest(rem);
            end else begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: list walking, backpressure, empty list,
// address wrap, flush and asynchronous reset.
module tb_lmsm_sequencer;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic busy, done;
  int   n_checks = 0;
  int   n_pass = 0;

  lmsm_sequencer_if #(.ADDR_W(16), .NREG(8)) bus ();

  lmsm_sequencer #(.ADDR_W(16), .NREG(8), .OP_LM(OP_LM), .OP_SM(OP_SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic chk_uop(input string tag, input int r, input int a, input bit ld);
    check($sformatf("%s.valid", tag), 32'(bus.uop_valid), 32'd1);
    check($sformatf("%s.reg", tag), 32'(bus.uop_reg), 32'(r));
    check($sformatf("%s.addr", tag), 32'(bus.uop_addr), 32'(a));
    check($sformatf("%s.load", tag), 32'(bus.uop_load), 32'(ld));
    check($sformatf("%s.busy", tag), 32'(busy), 32'd1);
  endtask

  // Called at a negedge; presents one instruction for a single rising edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] base, input logic [7:0] mask);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_base  = base;
    bus.in_mask  = mask;
    check("issue.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_done(input string tag);
    check($sformatf("%s.end_valid", tag), 32'(bus.uop_valid), 32'd0);
    check($sformatf("%s.done", tag), 32'(done), 32'd1);
    check($sformatf("%s.end_ready", tag), 32'(bus.in_ready), 32'd1);
    check($sformatf("%s.end_busy", tag), 32'(busy), 32'd0);
    @(negedge clk);
    check($sformatf("%s.done_pulse", tag), 32'(done), 32'd0);
  endtask

  initial begin
    int regs1 [4] = '{0, 2, 5, 7};
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'b0000;
    bus.in_base   = '0;
    bus.in_mask   = '0;
    bus.uop_ready = 1'b0;

    #12;
    check("rst.valid", 32'(bus.uop_valid), 32'd0);
    check("rst.reg", 32'(bus.uop_reg), 32'd0);
    check("rst.addr", 32'(bus.uop_addr), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LM 1010_0101 at 0x0100, continuous ready
    bus.uop_ready = 1'b1;
    issue(OP_LM, 16'h0100, 8'b1010_0101);
    for (int k = 0; k < 4; k++) begin
      chk_uop($sformatf("lm_a5[%0d]", k), regs1[k], 16'h0100 + k, 1'b1);
      @(negedge clk);
    end
    chk_done("lm_a5");

    // SM 0xFF at 0x0200, ready toggling
    issue(OP_SM, 16'h0200, 8'hFF);
    for (int k = 0; k < 8; k++) begin
      chk_uop($sformatf("sm_ff[%0d]", k), k, 16'h0200 + k, 1'b0);
      check($sformatf("sm_ff[%0d].nodone", k), 32'(done), 32'd0);
      bus.uop_ready = 1'b0;
      @(negedge clk);
      chk_uop($sformatf("sm_ff[%0d].hold", k), k, 16'h0200 + k, 1'b0);
      bus.uop_ready = 1'b1;
      @(negedge clk);
    end
    chk_done("sm_ff");

    // LM empty list: done one cycle after accept, no micro-op
    issue(OP_LM, 16'h0300, 8'h00);
    check("lm_00.valid", 32'(bus.uop_valid), 32'd0);
    check("lm_00.busy", 32'(busy), 32'd0);
    check("lm_00.done", 32'(done), 32'd1);
    @(negedge clk);
    check("lm_00.done_pulse", 32'(done), 32'd0);

    // SM across the address wrap
    issue(OP_SM, 16'hFFFF, 8'b1100_0000);
    chk_uop("sm_wrap[0]", 6, 16'hFFFF, 1'b0);
    @(negedge clk);
    chk_uop("sm_wrap[1]", 7, 16'h0000, 1'b0);
    @(negedge clk);
    chk_done("sm_wrap");

    // Flush after the 3rd handshake, with a competing instruction
    issue(OP_LM, 16'h0300, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      chk_uop($sformatf("fl[%0d]", k), k, 16'h0300 + k, 1'b1);
      @(negedge clk);
    end
    chk_uop("fl[3]", 3, 16'h0303, 1'b1);
    bus.uop_ready = 1'b0;
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = OP_LM;
    bus.in_base = 16'h0999;
    bus.in_mask = 8'h01;
    check("fl.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl.valid", 32'(bus.uop_valid), 32'd0);
    check("fl.done", 32'(done), 32'd0);
    check("fl.busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("fl.not_accepted", 32'(bus.uop_valid), 32'd0);
    check("fl.idle", 32'(busy), 32'd0);
    check("fl.nodone", 32'(done), 32'd0);
    bus.uop_ready = 1'b1;
    issue(OP_LM, 16'h0400, 8'b0001_1000);
    chk_uop("fl_new[0]", 3, 16'h0400, 1'b1);
    @(negedge clk);
    chk_uop("fl_new[1]", 4, 16'h0401, 1'b1);
    @(negedge clk);
    chk_done("fl_new");

    // Asynchronous reset mid-sequence
    issue(OP_SM, 16'h0500, 8'hFF);
    chk_uop("rs[0]", 0, 16'h0500, 1'b0);
    @(negedge clk);
    chk_uop("rs[1]", 1, 16'h0501, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rs.valid", 32'(bus.uop_valid), 32'd0);
    check("rs.reg", 32'(bus.uop_reg), 32'd0);
    check("rs.addr", 32'(bus.uop_addr), 32'd0);
    check("rs.load", 32'(bus.uop_load), 32'd0);
    check("rs.busy", 32'(busy), 32'd0);
    check("rs.done", 32'(done), 32'd0);
    @(negedge clk);
    check("rs.held_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-LM/SM opcode is never captured
    bus.in_valid = 1'b1;
    bus.in_op = 4'b0001;
    bus.in_base = 16'h0600;
    bus.in_mask = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("badop[%0d].valid", k), 32'(bus.uop_valid), 32'd0);
      check($sformatf("badop[%0d].busy", k), 32'(busy), 32'd0);
      check($sformatf("badop[%0d].done", k), 32'(done), 32'd0);
    end
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
